mem_bus_arb: RTL and testbench
==============================

MEM_BUS_ARB -- requirements
Module: mem_bus_arb

Interface
REQ-001 Parameter RoundRobin, default 1'b1: 1 selects round-robin arbitration; 0 gives m0 fixed priority.
REQ-002 Parameter Timeout, default 255: cycles to wait for a response before error-completion; 0 disables the watchdog.
REQ-003 clk  input  1  clock; single clock domain, all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-high (asserted = 1).
REQ-005 mN_req_i  input  1  request from master N (N=0: core LSU, N=1: debug/system master).
REQ-006 mN_addr_i / mN_wdata_i  input  32 each  address and write data from master N.
REQ-007 mN_we_i  input  1; mN_be_i  input  4  write enable and byte enables from master N.
REQ-008 mN_gnt_o  output  1  request from master N accepted this cycle.
REQ-009 mN_rvalid_o  output  1; mN_rdata_o  output  32; mN_err_o  output  1  response to master N.
REQ-010 s_req_o, s_we_o  output  1; s_addr_o, s_wdata_o  output  32; s_be_o  output  4  shared slave port.
REQ-011 s_gnt_i, s_rvalid_i  input  1; s_rdata_i  input  32  slave grant, response valid and read data.
REQ-012 busy_o  output  1  a transaction is in progress (state not IDLE).

Function
REQ-013 States SHALL be IDLE, REQ (slave request pending, no grant yet) and RSP (granted, waiting for the response); at most one transaction is outstanding.
REQ-014 In IDLE, the selected master's request SHALL drive s_req_o and the s_* payload combinationally, with zero cycles of latency.
REQ-015 In REQ, the latched owner SHALL drive the slave port, and the selection SHALL NOT change until s_gnt_i is asserted.
REQ-016 In RSP, s_req_o SHALL be 0.
REQ-017 When s_* is not driven by an owner, the s_* payload outputs SHALL be 0.
REQ-018 Selection with one requester SHALL grant that requester.
REQ-019 Selection with both requesting, RoundRobin=1, SHALL favour the master not in last_grant; with RoundRobin=0, SHALL favour m0.
REQ-020 mN_gnt_o SHALL equal s_req_o & s_gnt_i & (owner==N) in the same cycle.
REQ-021 The owner SHALL be latched and last_grant updated on every grant.
REQ-022 Transitions: IDLE->RSP on request with s_gnt_i; IDLE->REQ on request without s_gnt_i; REQ->RSP on s_gnt_i; RSP->IDLE on s_rvalid_i or on timeout.
REQ-023 On s_rvalid_i in RSP, the owner's mN_rvalid_o SHALL be 1 and mN_rdata_o SHALL equal s_rdata_i, with mN_err_o=0, in the same cycle.
REQ-024 Both masters' rdata SHALL be 0 otherwise.
REQ-025 Back-to-back rule: the next arbitration SHALL occur in the cycle after the return to IDLE, giving one bubble between transactions.
REQ-026 Watchdog: a counter SHALL clear on grant and increment each cycle in RSP.
REQ-027 When the counter reaches Timeout-1 with no s_rvalid_i (Timeout≠0), the owner SHALL receive mN_rvalid_o=1, mN_err_o=1 and rdata 0, and the state SHALL return to IDLE.
REQ-028 s_rvalid_i in the timeout cycle SHALL win, completing normally with no error.
REQ-029 s_rvalid_i in IDLE or REQ (spurious or late) SHALL be ignored and SHALL produce no master rvalid.
REQ-030 A master deasserting req in REQ is a protocol violation; the arbiter SHALL keep the owner and keep s_req_o asserted regardless.

Reset
REQ-031 Reset SHALL force state IDLE, last_grant=1 (so m0 wins the first tie), owner=0 and counter=0.
REQ-032 During reset all outputs SHALL be 0, except the combinational IDLE path, which SHALL be masked to 0 while rst_n=1.
REQ-033 Reset during RSP SHALL abandon the transaction; a subsequent s_rvalid_i SHALL be dropped per REQ-029.

Structure
REQ-034 The state enum (IDLE/REQ/RSP) and the master-index width constant SHALL live in the shared core defines package.
REQ-035 No sub-module is required; the watchdog counter width SHALL be $clog2(Timeout+1).

Verification
REQ-036 m0 requests addr 0x1000 read, s_gnt_i=1 same cycle, s_rvalid_i after 2 cycles with 0xDEADBEEF -> m0_gnt_o in cycle 0, m0_rvalid_o=1 with rdata 0xDEADBEEF in cycle 2, m1 outputs all 0.
REQ-037 Both request continuously with RoundRobin=1 and 4 single-cycle-response transactions -> grant order m0,m1,m0,m1; with RoundRobin=0 -> m0,m0,m0,m0.
REQ-038 m1 requests, s_gnt_i held low 3 cycles, then m0 also requests -> s_addr_o stays m1's address and m1_gnt_o fires when s_gnt_i rises.
REQ-039 Timeout=4, granted, no s_rvalid_i -> owner rvalid=1, err=1, rdata=0 exactly 4 cycles after grant; a late s_rvalid_i one cycle later is ignored.
REQ-040 rst_n=1 asserted mid-RSP, then s_rvalid_i arrives after release -> no master rvalid, state IDLE, next tie granted to m0.

Source files
------------

// File: rtl/mem_bus_arb_pkg.sv
// rtl/mem_bus_arb_pkg.sv - shared state and index definitions for the two-master bus arbiter
package mem_bus_arb_pkg;

  localparam int MIDX_W = 1;

  typedef logic [MIDX_W-1:0] midx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

endpackage

// File: rtl/mem_bus_arb_if.sv
// rtl/mem_bus_arb_if.sv - master-side and slave-side bus signals of the arbiter
interface mem_bus_arb_if;

  logic        m0_req_i;
  logic [31:0] m0_addr_i;
  logic [31:0] m0_wdata_i;
  logic        m0_we_i;
  logic [3:0]  m0_be_i;
  logic        m0_gnt_o;
  logic        m0_rvalid_o;
  logic [31:0] m0_rdata_o;
  logic        m0_err_o;

  logic        m1_req_i;
  logic [31:0] m1_addr_i;
  logic [31:0] m1_wdata_i;
  logic        m1_we_i;
  logic [3:0]  m1_be_i;
  logic        m1_gnt_o;
  logic        m1_rvalid_o;
  logic [31:0] m1_rdata_o;
  logic        m1_err_o;

  logic        s_req_o;
  logic        s_we_o;
  logic [31:0] s_addr_o;
  logic [31:0] s_wdata_o;
  logic [3:0]  s_be_o;
  logic        s_gnt_i;
  logic        s_rvalid_i;
  logic [31:0] s_rdata_i;

  // Arbiter view.
  modport slave (
    input  m0_req_i, m0_addr_i, m0_wdata_i, m0_we_i, m0_be_i,
    input  m1_req_i, m1_addr_i, m1_wdata_i, m1_we_i, m1_be_i,
    input  s_gnt_i, s_rvalid_i, s_rdata_i,
    output m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
    output m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
    output s_req_o, s_we_o, s_addr_o, s_wdata_o, s_be_o
  );

  // Environment view: requesting masters plus the memory slave.
  modport master (
    output m0_req_i, m0_addr_i, m0_wdata_i, m0_we_i, m0_be_i,
    output m1_req_i, m1_addr_i, m1_wdata_i, m1_we_i, m1_be_i,
    output s_gnt_i, s_rvalid_i, s_rdata_i,
    input  m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
    input  m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
    input  s_req_o, s_we_o, s_addr_o, s_wdata_o, s_be_o
  );

endinterface

// File: rtl/mem_bus_arb.sv
// rtl/mem_bus_arb.sv - two-master, one-outstanding memory bus arbiter with response watchdog
module mem_bus_arb
  import mem_bus_arb_pkg::*;
#(
  parameter bit RoundRobin = 1'b1,
  parameter int Timeout    = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_bus_arb_if.slave  bus,
  output logic          busy_o
);

  localparam int          CntW    = (Timeout > 0) ? $clog2(Timeout + 1) : 1;
  localparam bit          WdogEn  = (Timeout != 0);
  localparam [CntW-1:0]   TmoLast = CntW'((Timeout > 0) ? Timeout - 1 : 0);

  state_t          state;
  midx_t           owner;
  midx_t           last_grant;
  logic [CntW-1:0] cnt;

  logic  any_req;
  midx_t sel;
  midx_t drv;
  logic  s_req;
  logic  gnt;
  logic  rsp_done;
  logic  tmo;

  always_comb begin
    any_req = bus.m0_req_i | bus.m1_req_i;
    sel     = midx_t'(0);
    if (bus.m0_req_i && bus.m1_req_i) begin
      sel = (RoundRobin && last_grant == midx_t'(0)) ? midx_t'(1) : midx_t'(0);
    end else if (bus.m1_req_i) begin
      sel = midx_t'(1);
    end
  end

  // In IDLE the live selection drives the slave; afterwards only the latched owner does.
  assign drv   = (state == IDLE) ? sel : owner;
  assign s_req = !rst_n && ((state == IDLE && any_req) || state == REQ);
  assign gnt   = s_req && bus.s_gnt_i;

  assign rsp_done = !rst_n && state == RSP && bus.s_rvalid_i;
  assign tmo      = WdogEn && !rst_n && state == RSP && !bus.s_rvalid_i && cnt == TmoLast;

  assign bus.s_req_o   = s_req;
  assign bus.s_addr_o  = !s_req ? '0 : (drv == midx_t'(0)) ? bus.m0_addr_i  : bus.m1_addr_i;
  assign bus.s_wdata_o = !s_req ? '0 : (drv == midx_t'(0)) ? bus.m0_wdata_i : bus.m1_wdata_i;
  assign bus.s_we_o    = !s_req ? '0 : (drv == midx_t'(0)) ? bus.m0_we_i    : bus.m1_we_i;
  assign bus.s_be_o    = !s_req ? '0 : (drv == midx_t'(0)) ? bus.m0_be_i    : bus.m1_be_i;

  assign bus.m0_gnt_o    = gnt && drv == midx_t'(0);
  assign bus.m1_gnt_o    = gnt && drv == midx_t'(1);
  assign bus.m0_rvalid_o = (rsp_done || tmo) && owner == midx_t'(0);
  assign bus.m1_rvalid_o = (rsp_done || tmo) && owner == midx_t'(1);
  assign bus.m0_err_o    = tmo && owner == midx_t'(0);
  assign bus.m1_err_o    = tmo && owner == midx_t'(1);
  assign bus.m0_rdata_o  = (rsp_done && owner == midx_t'(0)) ? bus.s_rdata_i : '0;
  assign bus.m1_rdata_o  = (rsp_done && owner == midx_t'(1)) ? bus.s_rdata_i : '0;

  assign busy_o = !rst_n && state != IDLE;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state      <= IDLE;
      owner      <= midx_t'(0);
      last_grant <= midx_t'(1);
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner <= sel;
            if (bus.s_gnt_i) begin
              state      <= RSP;
              last_grant <= sel;
              cnt        <= '0;
            end else begin
              state <= REQ;
            end
          end
        end
        REQ: begin
          if (bus.s_gnt_i) begin
            state      <= RSP;
            last_grant <= owner;
            cnt        <= '0;
          end
        end
        RSP: begin
          if (bus.s_rvalid_i || tmo) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arb.sv
// tb/tb_mem_bus_arb.sv - directed self-checking bench for mem_bus_arb
module tb_mem_bus_arb;

  logic clk = 1'b0;
  logic rst_n;
  logic busy_rr;
  logic busy_fp;
  int   checks = 0;
  int   errors = 0;

  mem_bus_arb_if bi_rr ();
  mem_bus_arb_if bi_fp ();

  mem_bus_arb #(.RoundRobin(1'b1), .Timeout(4)) u_rr (
    .clk(clk), .rst_n(rst_n), .bus(bi_rr), .busy_o(busy_rr)
  );

  mem_bus_arb #(.RoundRobin(1'b0), .Timeout(0)) u_fp (
    .clk(clk), .rst_n(rst_n), .bus(bi_fp), .busy_o(busy_fp)
  );

  assign bi_fp.m0_req_i   = bi_rr.m0_req_i;
  assign bi_fp.m0_addr_i  = bi_rr.m0_addr_i;
  assign bi_fp.m0_wdata_i = bi_rr.m0_wdata_i;
  assign bi_fp.m0_we_i    = bi_rr.m0_we_i;
  assign bi_fp.m0_be_i    = bi_rr.m0_be_i;
  assign bi_fp.m1_req_i   = bi_rr.m1_req_i;
  assign bi_fp.m1_addr_i  = bi_rr.m1_addr_i;
  assign bi_fp.m1_wdata_i = bi_rr.m1_wdata_i;
  assign bi_fp.m1_we_i    = bi_rr.m1_we_i;
  assign bi_fp.m1_be_i    = bi_rr.m1_be_i;
  assign bi_fp.s_gnt_i    = bi_rr.s_gnt_i;
  assign bi_fp.s_rvalid_i = bi_rr.s_rvalid_i;
  assign bi_fp.s_rdata_i  = bi_rr.s_rdata_i;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bi_rr.m0_req_i   = 1'b0;
    bi_rr.m0_addr_i  = '0;
    bi_rr.m0_wdata_i = '0;
    bi_rr.m0_we_i    = 1'b0;
    bi_rr.m0_be_i    = '0;
    bi_rr.m1_req_i   = 1'b0;
    bi_rr.m1_addr_i  = '0;
    bi_rr.m1_wdata_i = '0;
    bi_rr.m1_we_i    = 1'b0;
    bi_rr.m1_be_i    = '0;
    bi_rr.s_gnt_i    = 1'b0;
    bi_rr.s_rvalid_i = 1'b0;
    bi_rr.s_rdata_i  = '0;
  endtask

  initial begin
    // Reset with a live request: the IDLE path must stay masked.
    rst_n = 1'b1;
    idle_inputs();
    bi_rr.m0_req_i  = 1'b1;
    bi_rr.m0_addr_i = 32'h0000_1000;
    bi_rr.s_gnt_i   = 1'b1;
    @(negedge clk);
    chk("rst_s_req", 32'(bi_rr.s_req_o), 32'd0);
    chk("rst_s_addr", bi_rr.s_addr_o, 32'd0);
    chk("rst_m0_gnt", 32'(bi_rr.m0_gnt_o), 32'd0);
    chk("rst_busy", 32'(busy_rr), 32'd0);
    tick();
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk("idle_busy", 32'(busy_rr), 32'd0);
    chk("idle_s_req", 32'(bi_rr.s_req_o), 32'd0);

    // Single read by m0 with same-cycle grant and response two cycles later.
    tick();
    bi_rr.m0_req_i  = 1'b1;
    bi_rr.m0_addr_i = 32'h0000_1000;
    bi_rr.m0_be_i   = 4'hF;
    bi_rr.s_gnt_i   = 1'b1;
    @(negedge clk);
    chk("rd_s_req", 32'(bi_rr.s_req_o), 32'd1);
    chk("rd_s_addr", bi_rr.s_addr_o, 32'h0000_1000);
    chk("rd_s_be", 32'(bi_rr.s_be_o), 32'hF);
    chk("rd_m0_gnt", 32'(bi_rr.m0_gnt_o), 32'd1);
    chk("rd_m1_gnt", 32'(bi_rr.m1_gnt_o), 32'd0);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("rd_busy", 32'(busy_rr), 32'd1);
    chk("rd_rsp_s_req", 32'(bi_rr.s_req_o), 32'd0);
    chk("rd_early_rvalid", 32'(bi_rr.m0_rvalid_o), 32'd0);
    tick();
    bi_rr.s_rvalid_i = 1'b1;
    bi_rr.s_rdata_i  = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rd_m0_rvalid", 32'(bi_rr.m0_rvalid_o), 32'd1);
    chk("rd_m0_rdata", bi_rr.m0_rdata_o, 32'hDEAD_BEEF);
    chk("rd_m0_err", 32'(bi_rr.m0_err_o), 32'd0);
    chk("rd_m1_rvalid", 32'(bi_rr.m1_rvalid_o), 32'd0);
    chk("rd_m1_rdata", bi_rr.m1_rdata_o, 32'd0);
    chk("rd_m1_err", 32'(bi_rr.m1_err_o), 32'd0);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("rd_done_busy", 32'(busy_rr), 32'd0);

    // Both masters requesting continuously; response always ready.
    tick();
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    bi_rr.m0_req_i   = 1'b1;
    bi_rr.m0_addr_i  = 32'h0000_00A0;
    bi_rr.m1_req_i   = 1'b1;
    bi_rr.m1_addr_i  = 32'h0000_00B0;
    bi_rr.s_gnt_i    = 1'b1;
    bi_rr.s_rvalid_i = 1'b1;
    bi_rr.s_rdata_i  = 32'h0000_0042;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i % 2 == 0) begin
        chk($sformatf("rr_m0_gnt_%0d", i), 32'(bi_rr.m0_gnt_o), 32'(i % 4 == 0));
        chk($sformatf("rr_m1_gnt_%0d", i), 32'(bi_rr.m1_gnt_o), 32'(i % 4 == 2));
        chk($sformatf("rr_addr_%0d", i), bi_rr.s_addr_o, (i % 4 == 0) ? 32'h0000_00A0 : 32'h0000_00B0);
        chk($sformatf("fp_m0_gnt_%0d", i), 32'(bi_fp.m0_gnt_o), 32'd1);
        chk($sformatf("fp_m1_gnt_%0d", i), 32'(bi_fp.m1_gnt_o), 32'd0);
      end else begin
        chk($sformatf("rr_bubble_gnt_%0d", i), 32'({bi_rr.m0_gnt_o, bi_rr.m1_gnt_o}), 32'd0);
        chk($sformatf("rr_m0_rvalid_%0d", i), 32'(bi_rr.m0_rvalid_o), 32'(i % 4 == 1));
        chk($sformatf("rr_m1_rvalid_%0d", i), 32'(bi_rr.m1_rvalid_o), 32'(i % 4 == 3));
      end
    end
    tick();
    idle_inputs();

    // m1 waits for the slave; m0 joins but cannot steal the latched selection.
    tick();
    bi_rr.m1_req_i   = 1'b1;
    bi_rr.m1_addr_i  = 32'h0000_2000;
    bi_rr.m1_wdata_i = 32'h1234_5678;
    bi_rr.m1_we_i    = 1'b1;
    bi_rr.m1_be_i    = 4'h3;
    @(negedge clk);
    chk("hold_c0_s_req", 32'(bi_rr.s_req_o), 32'd1);
    chk("hold_c0_addr", bi_rr.s_addr_o, 32'h0000_2000);
    chk("hold_c0_wdata", bi_rr.s_wdata_o, 32'h1234_5678);
    chk("hold_c0_we", 32'(bi_rr.s_we_o), 32'd1);
    chk("hold_c0_m1_gnt", 32'(bi_rr.m1_gnt_o), 32'd0);
    tick();
    bi_rr.m0_req_i   = 1'b1;
    bi_rr.m0_addr_i  = 32'h0000_1000;
    bi_rr.s_rvalid_i = 1'b1;
    @(negedge clk);
    chk("hold_c1_addr", bi_rr.s_addr_o, 32'h0000_2000);
    chk("hold_c1_busy", 32'(busy_rr), 32'd1);
    chk("spurious_m1_rvalid", 32'(bi_rr.m1_rvalid_o), 32'd0);
    chk("spurious_m0_rvalid", 32'(bi_rr.m0_rvalid_o), 32'd0);
    tick();
    bi_rr.s_rvalid_i = 1'b0;
    bi_rr.m1_req_i   = 1'b0;
    @(negedge clk);
    chk("hold_c2_s_req", 32'(bi_rr.s_req_o), 32'd1);
    chk("hold_c2_addr", bi_rr.s_addr_o, 32'h0000_2000);
    tick();
    bi_rr.s_gnt_i = 1'b1;
    @(negedge clk);
    chk("hold_c3_m1_gnt", 32'(bi_rr.m1_gnt_o), 32'd1);
    chk("hold_c3_m0_gnt", 32'(bi_rr.m0_gnt_o), 32'd0);
    chk("hold_c3_addr", bi_rr.s_addr_o, 32'h0000_2000);
    tick();
    idle_inputs();
    bi_rr.s_rvalid_i = 1'b1;
    bi_rr.s_rdata_i  = 32'hCAFE_F00D;
    @(negedge clk);
    chk("hold_m1_rvalid", 32'(bi_rr.m1_rvalid_o), 32'd1);
    chk("hold_m1_rdata", bi_rr.m1_rdata_o, 32'hCAFE_F00D);
    chk("hold_m0_rvalid", 32'(bi_rr.m0_rvalid_o), 32'd0);
    chk("hold_rsp_addr", bi_rr.s_addr_o, 32'd0);
    tick();
    idle_inputs();

    // Watchdog: Timeout=4 on the round-robin instance, disabled on the other.
    tick();
    bi_rr.m0_req_i  = 1'b1;
    bi_rr.m0_addr_i = 32'h0000_3000;
    bi_rr.s_gnt_i   = 1'b1;
    @(negedge clk);
    chk("tmo_m0_gnt", 32'(bi_rr.m0_gnt_o), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      idle_inputs();
      @(negedge clk);
      chk($sformatf("tmo_rvalid_%0d", k), 32'(bi_rr.m0_rvalid_o), 32'(k == 4));
      chk($sformatf("tmo_err_%0d", k), 32'(bi_rr.m0_err_o), 32'(k == 4));
      chk($sformatf("tmo_rdata_%0d", k), bi_rr.m0_rdata_o, 32'd0);
      chk($sformatf("nowd_rvalid_%0d", k), 32'(bi_fp.m0_rvalid_o), 32'd0);
    end
    tick();
    bi_rr.s_rvalid_i = 1'b1;
    bi_rr.s_rdata_i  = 32'h55AA_55AA;
    @(negedge clk);
    chk("late_m0_rvalid", 32'(bi_rr.m0_rvalid_o), 32'd0);
    chk("late_busy", 32'(busy_rr), 32'd0);
    chk("nowd_m0_rvalid", 32'(bi_fp.m0_rvalid_o), 32'd1);
    chk("nowd_m0_rdata", bi_fp.m0_rdata_o, 32'h55AA_55AA);
    chk("nowd_m0_err", 32'(bi_fp.m0_err_o), 32'd0);
    tick();
    idle_inputs();

    // Reset in RSP abandons the transaction; the stray response is dropped.
    tick();
    bi_rr.m0_req_i = 1'b1;
    bi_rr.s_gnt_i  = 1'b1;
    @(negedge clk);
    chk("mid_m0_gnt", 32'(bi_rr.m0_gnt_o), 32'd1);
    tick();
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy_rr), 32'd0);
    tick();
    rst_n = 1'b0;
    bi_rr.s_rvalid_i = 1'b1;
    bi_rr.s_rdata_i  = 32'h0000_0077;
    @(negedge clk);
    chk("mid_m0_rvalid", 32'(bi_rr.m0_rvalid_o), 32'd0);
    chk("mid_m1_rvalid", 32'(bi_rr.m1_rvalid_o), 32'd0);
    chk("mid_busy", 32'(busy_rr), 32'd0);
    tick();
    idle_inputs();
    bi_rr.m0_req_i = 1'b1;
    bi_rr.m1_req_i = 1'b1;
    bi_rr.s_gnt_i  = 1'b1;
    @(negedge clk);
    chk("mid_tie_m0_gnt", 32'(bi_rr.m0_gnt_o), 32'd1);
    chk("mid_tie_m1_gnt", 32'(bi_rr.m1_gnt_o), 32'd0);
    tick();
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
